// File: rtl/store_rmw_if.sv
// Request/memory bundle for store_rmw_ctrl: the master drives the store request and
// the memory read data, the slave (the controller) drives status and memory controls.
interface store_rmw_if;
   logic        req;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        align_err;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output req, size, addr, wdata, mem_rdata,
      input  busy, done, align_err, mem_addr, mem_wr, mem_wdata
   );

   modport slave (
      input  req, size, addr, wdata, mem_rdata,
      output busy, done, align_err, mem_addr, mem_wr, mem_wdata
   );
endinterface

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sb/sh/sw stores into a single-port word memory.
// Define STORE_RMW_ALIGN_CHECK_EN to trap misaligned halfword/word stores in an ERR state.
module store_rmw_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         reset,
   store_rmw_if.slave   bus
);

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

`ifdef STORE_RMW_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
`endif

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_addr_q;
   logic [1:0]  r_size_q;
   logic [31:0] r_wdata_q;
   logic [31:0] r_rd_q;
   logic [2:0]  r_lat_cnt;
   logic        w_accept;
   logic        w_subword;
   logic        w_busy;
   logic        w_done;
   logic        w_mem_wr;
   logic        w_align_err;
`ifdef STORE_RMW_ALIGN_CHECK_EN
   logic        w_misalign;
`endif

   // Little-endian lane merge; size 00 and 11 both replace the whole word.
   function automatic logic [31:0] f_merge(input logic [31:0] rd,
                                           input logic [31:0] wd,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  off);
      logic [31:0] m;
      m = rd;
      case (sz)
         2'b10: begin
            case (off)
               2'd0:    m[7:0]   = wd[7:0];
               2'd1:    m[15:8]  = wd[7:0];
               2'd2:    m[23:16] = wd[7:0];
               default: m[31:24] = wd[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) m[31:16] = wd[15:0];
            else        m[15:0]  = wd[15:0];
         end
         default: m = wd;
      endcase
      return m;
   endfunction

   assign w_accept  = (r_state == S_IDLE) && bus.req;
   assign w_subword = (bus.size == 2'b01) || (bus.size == 2'b10);

`ifdef STORE_RMW_ALIGN_CHECK_EN
   assign w_misalign = ((bus.size == 2'b01) && bus.addr[0]) ||
                       (((bus.size == 2'b00) || (bus.size == 2'b11)) && (bus.addr[1:0] != 2'b00));
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_mem_wr    = 1'b0;
      w_align_err = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.req) begin
`ifdef STORE_RMW_ALIGN_CHECK_EN
               if (w_misalign)     w_next = S_ERR;
               else if (w_subword) w_next = S_READ;
               else                w_next = S_WRITE;
`else
               if (w_subword) w_next = S_READ;
               else           w_next = S_WRITE;
`endif
            end
         end
         S_READ: begin
            if (r_lat_cnt == 3'd0) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_mem_wr = 1'b1;
            w_next   = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
`ifdef STORE_RMW_ALIGN_CHECK_EN
         S_ERR: begin
            w_align_err = 1'b1;
            w_next      = S_IDLE;
         end
`endif
         default: begin
            w_busy = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   // Transaction registers; the read word is captured in the last READ cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_q  <= '0;
         r_size_q  <= '0;
         r_wdata_q <= '0;
         r_rd_q    <= '0;
         r_lat_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_addr_q  <= bus.addr;
            r_size_q  <= bus.size;
            r_wdata_q <= bus.wdata;
            r_lat_cnt <= w_subword ? LAT_INIT : 3'd0;
         end
         if (r_state == S_READ) begin
            if (r_lat_cnt == 3'd0) r_rd_q    <= bus.mem_rdata;
            else                   r_lat_cnt <= r_lat_cnt - 3'd1;
         end
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.align_err = w_align_err;
   assign bus.mem_wr    = w_mem_wr;
   assign bus.mem_addr  = {r_addr_q[31:2], 2'b00};
   assign bus.mem_wdata = f_merge(r_rd_q, r_wdata_q, r_size_q, r_addr_q[1:0]);

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with MEM_LAT=1 and MEM_LAT=3 instances.
module tb_store_rmw_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   store_rmw_if ifc1();
   store_rmw_if ifc3();

   store_rmw_ctrl #(.MEM_LAT(1)) u_lat1 (.clk(clk), .reset(reset), .bus(ifc1.slave));
   store_rmw_ctrl #(.MEM_LAT(3)) u_lat3 (.clk(clk), .reset(reset), .bus(ifc3.slave));

   int errors = 0;
   int checks = 0;
   int cur_sel = 1;

   logic        w_wr, w_busy, w_done, w_aerr;
   logic [31:0] w_wdata, w_addr;
   assign w_wr    = (cur_sel == 3) ? ifc3.mem_wr    : ifc1.mem_wr;
   assign w_busy  = (cur_sel == 3) ? ifc3.busy      : ifc1.busy;
   assign w_done  = (cur_sel == 3) ? ifc3.done      : ifc1.done;
   assign w_aerr  = (cur_sel == 3) ? ifc3.align_err : ifc1.align_err;
   assign w_wdata = (cur_sel == 3) ? ifc3.mem_wdata : ifc1.mem_wdata;
   assign w_addr  = (cur_sel == 3) ? ifc3.mem_addr  : ifc1.mem_addr;

   int          wr_cnt, wr_cyc, done_cnt, done_cyc, aerr_cnt, aerr_cyc, idle_cyc, overlap;
   logic [31:0] wr_data, wr_addr;

   task automatic set_req(input int sel, input logic r, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
      if (sel == 3) begin
         ifc3.req = r; ifc3.size = sz; ifc3.addr = a; ifc3.wdata = wd;
      end else begin
         ifc1.req = r; ifc1.size = sz; ifc1.addr = a; ifc1.wdata = wd;
      end
   endtask

   task automatic clear_obs();
      wr_cnt = 0; wr_cyc = -1; done_cnt = 0; done_cyc = -1;
      aerr_cnt = 0; aerr_cyc = -1; idle_cyc = -1; overlap = 0;
      wr_data = '0; wr_addr = '0;
   endtask

   task automatic sample_obs(input int c);
      if (w_wr) begin wr_cnt++; wr_cyc = c; wr_data = w_wdata; wr_addr = w_addr; end
      if (w_done) begin done_cnt++; done_cyc = c; end
      if (w_aerr) begin aerr_cnt++; aerr_cyc = c; end
      if (w_wr && w_done) overlap++;
   endtask

   // One-shot store; cycle c counts from the cycle after the accepting edge.
   task automatic run_store(input int sel, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
      cur_sel = sel;
      clear_obs();
      @(negedge clk);
      set_req(sel, 1'b1, sz, a, wd);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) set_req(sel, 1'b0, 2'b00, 32'h0, 32'h0);
         sample_obs(c);
         if (!w_busy) begin idle_cyc = c; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ifc1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifc1.busy); end
      checks++; if (ifc1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", ifc1.done); end
      checks++; if (ifc1.align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b want 0", ifc1.align_err); end
      checks++; if (ifc1.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", ifc1.mem_wr); end
      checks++; if (ifc1.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", ifc1.mem_addr); end
      checks++; if (ifc1.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", ifc1.mem_wdata); end
      checks++; if (ifc3.busy !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b want 0", ifc3.busy); end
      reset = 1'b0;
   endtask

   task automatic test_word();
      run_store(1, 2'b00, 32'h0000_0104, 32'hDEAD_BEEF);
      checks++; if (wr_cyc !== 1) begin errors++; $display("FAIL word_wr_cycle: got %0d want 1", wr_cyc); end
      checks++; if (wr_addr !== 32'h104) begin errors++; $display("FAIL word_addr: got %h want 00000104", wr_addr); end
      checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_data: got %h want deadbeef", wr_data); end
      checks++; if (done_cyc !== 2) begin errors++; $display("FAIL word_done_cycle: got %0d want 2", done_cyc); end
      checks++; if (wr_cnt !== 1 || done_cnt !== 1) begin errors++; $display("FAIL word_pulses: got wr=%0d done=%0d want 1/1", wr_cnt, done_cnt); end
      checks++; if (idle_cyc !== 3) begin errors++; $display("FAIL word_idle_cycle: got %0d want 3", idle_cyc); end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL word_wr_done_overlap: got %0d want 0", overlap); end
   endtask

   task automatic test_byte_sweep();
      logic [31:0] exp_b [4];
      exp_b = '{32'h1122_33AA, 32'h1122_AA44, 32'h11AA_3344, 32'hAA22_3344};
      for (int off = 0; off < 4; off++) begin
         run_store(1, 2'b10, 32'h40 + 32'(off), 32'h0000_00AA);
         checks++; if (wr_data !== exp_b[off]) begin errors++; $display("FAIL byte_data off=%0d: got %h want %h", off, wr_data, exp_b[off]); end
         checks++; if (wr_addr !== 32'h40) begin errors++; $display("FAIL byte_addr off=%0d: got %h want 00000040", off, wr_addr); end
         checks++; if (wr_cyc !== 2 || done_cyc !== 3) begin errors++; $display("FAIL byte_timing off=%0d: got wr=%0d done=%0d want 2/3", off, wr_cyc, done_cyc); end
      end
   endtask

   task automatic test_halfword();
      run_store(3, 2'b01, 32'h0000_0202, 32'h0000_BEEF);
      checks++; if (wr_data !== 32'hBEEF_3344) begin errors++; $display("FAIL half_hi_data: got %h want beef3344", wr_data); end
      checks++; if (wr_addr !== 32'h200) begin errors++; $display("FAIL half_hi_addr: got %h want 00000200", wr_addr); end
      checks++; if (wr_cyc !== 4) begin errors++; $display("FAIL half_hi_wr_cycle: got %0d want 4", wr_cyc); end
      checks++; if (done_cyc !== 5) begin errors++; $display("FAIL half_hi_done_cycle: got %0d want 5", done_cyc); end
      run_store(3, 2'b01, 32'h0000_0200, 32'h0000_BEEF);
      checks++; if (wr_data !== 32'h1122_BEEF) begin errors++; $display("FAIL half_lo_data: got %h want 1122beef", wr_data); end
      checks++; if (wr_cyc !== 4 || done_cyc !== 5) begin errors++; $display("FAIL half_lo_timing: got wr=%0d done=%0d want 4/5", wr_cyc, done_cyc); end
   endtask

   task automatic test_reset_abort();
      cur_sel = 3;
      clear_obs();
      @(negedge clk);
      set_req(3, 1'b1, 2'b10, 32'h0000_0011, 32'h0000_00AA);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) set_req(3, 1'b0, 2'b00, 32'h0, 32'h0);
         if (c == 3) begin
            reset = 1'b0;
            checks++; if (ifc3.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", ifc3.busy); end
            checks++; if (ifc3.mem_addr !== 32'h0) begin errors++; $display("FAIL abort_mem_addr: got %h want 0", ifc3.mem_addr); end
         end
         sample_obs(c);
         if (c == 2) reset = 1'b1;
      end
      checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL abort_no_write: got %0d writes want 0", wr_cnt); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones want 0", done_cnt); end
      run_store(3, 2'b00, 32'h0000_0108, 32'h1234_5678);
      checks++; if (wr_cyc !== 1 || wr_data !== 32'h1234_5678 || wr_addr !== 32'h108) begin
         errors++; $display("FAIL abort_next_word: got cyc=%0d data=%h addr=%h want 1/12345678/00000108", wr_cyc, wr_data, wr_addr);
      end
      checks++; if (done_cyc !== 2) begin errors++; $display("FAIL abort_next_done: got %0d want 2", done_cyc); end
   endtask

   task automatic test_back_to_back();
      logic [8:1] busy_m, wr_m, done_m;
      busy_m = '0; wr_m = '0; done_m = '0;
      cur_sel = 1;
      @(negedge clk);
      set_req(1, 1'b1, 2'b00, 32'h0000_0120, 32'hCAFE_F00D);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         busy_m[c] = w_busy;
         wr_m[c]   = w_wr;
         done_m[c] = w_done;
         if (c == 4) set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
      end
      checks++; if (wr_m !== 8'b0000_1001) begin errors++; $display("FAIL b2b_writes: got %b want 00001001", wr_m); end
      checks++; if (done_m !== 8'b0001_0010) begin errors++; $display("FAIL b2b_dones: got %b want 00010010", done_m); end
      checks++; if (busy_m !== 8'b0001_1011) begin errors++; $display("FAIL b2b_busy: got %b want 00011011", busy_m); end
   endtask

   task automatic test_align();
      run_store(1, 2'b01, 32'h0000_0301, 32'h0000_BEEF);
`ifdef STORE_RMW_ALIGN_CHECK_EN
      checks++; if (aerr_cyc !== 1 || aerr_cnt !== 1) begin errors++; $display("FAIL align_pulse: got cyc=%0d cnt=%0d want 1/1", aerr_cyc, aerr_cnt); end
      checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL align_no_write: got %0d want 0", wr_cnt); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL align_no_done: got %0d want 0", done_cnt); end
      checks++; if (idle_cyc !== 2) begin errors++; $display("FAIL align_idle_cycle: got %0d want 2", idle_cyc); end
`else
      checks++; if (wr_data !== 32'h1122_BEEF) begin errors++; $display("FAIL unaligned_half_data: got %h want 1122beef", wr_data); end
      checks++; if (wr_addr !== 32'h300) begin errors++; $display("FAIL unaligned_half_addr: got %h want 00000300", wr_addr); end
      checks++; if (wr_cyc !== 2 || done_cyc !== 3) begin errors++; $display("FAIL unaligned_half_timing: got wr=%0d done=%0d want 2/3", wr_cyc, done_cyc); end
      checks++; if (aerr_cnt !== 0) begin errors++; $display("FAIL unaligned_half_align_err: got %0d want 0", aerr_cnt); end
`endif
   endtask

   initial begin
      set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(3, 1'b0, 2'b00, 32'h0, 32'h0);
      ifc1.mem_rdata = 32'h1122_3344;
      ifc3.mem_rdata = 32'h1122_3344;
      test_reset();
      test_word();
      test_byte_sweep();
      test_halfword();
      test_reset_abort();
      test_back_to_back();
      test_align();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/store_rmw_ctrl.md
# store_rmw_ctrl

Read-modify-write sequencer for MIPS sub-word stores (sb/sh) in the multicycle datapath. It accepts a store request from the control unit, reads the containing memory word, and merges the byte or halfword into the correct lane. It then writes the merged word back and signals completion. Word stores (sw) bypass the read phase. The block sits between the control unit/ALU address path and the single-port data memory, and owns the memory's address and write-enable during a transaction.

## Interface
- MEM_LAT, 1: memory read latency in cycles, legal range 1..8; read data is valid on mem_rdata in the last READ cycle.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  store request; sampled only in IDLE.
- size  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- addr  in  32  byte address of the store.
- wdata  in  32  store data; byte uses [7:0], halfword uses [15:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- align_err  out  1  one-cycle misalignment pulse (see Configuration).
- mem_addr  out  32  word-aligned memory address {addr_q[31:2],2'b00}.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, READ, WRITE, DONE, plus ERR when the alignment check is compiled in.
- IDLE with req=1: register addr, size and wdata into addr_q, size_q and wdata_q, then:
  - size 00/11: go to WRITE.
  - size 01/10: go to READ, load lat_cnt=MEM_LAT-1.
- req while busy=1 is ignored, including in DONE; no queueing.
- READ: mem_wr=0, mem_addr driven. lat_cnt decrements each cycle. When lat_cnt==0, capture mem_rdata into rd_q and go to WRITE.
- Merge is little-endian, from rd_q and wdata_q, using offset=addr_q[1:0]:
  - Byte, offset 0..3: lane [8*off+7:8*off] = wdata_q[7:0]; other lanes from rd_q.
  - Halfword, addr_q[1]=0: [15:0] = wdata_q[15:0], [31:16] from rd_q.
  - Halfword, addr_q[1]=1: [31:16] = wdata_q[15:0], [15:0] from rd_q.
  - Word: mem_wdata = wdata_q.
- WRITE: mem_wr=1 for exactly one cycle with mem_wdata registered/stable, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- mem_addr is held constant from the cycle after acceptance until return to IDLE.

## Timing
- Reset values: busy=0, done=0, align_err=0, mem_wr=0, mem_addr=0, mem_wdata=0. State is IDLE and all internal registers are 0.
- req accepted at edge E0.
- Word store: WRITE in cycle E0+1, done in cycle E0+2. Total 2 cycles; back-to-back req accepted at E0+3.
- Sub-word store: READ in cycles E0+1..E0+MEM_LAT, WRITE in E0+MEM_LAT+1, done in E0+MEM_LAT+2.
- reset asserted in any state: at the next edge the state is IDLE and mem_wr=0. No done or align_err pulse for the aborted transaction; a write in progress in that cycle is dropped.
- reset and req in the same cycle: reset wins and req is not accepted.
- mem_wr and done are never high in the same cycle.

## Configuration
- Macro: STORE_RMW_ALIGN_CHECK_EN.
- Defined: at acceptance, the alignment check runs before any memory access:
  - A halfword with addr[0]=1 is misaligned.
  - A word with addr[1:0]!=0 is misaligned.
  - On misalignment: go to ERR, where align_err=1 for one cycle, busy=1 and mem_wr stays 0, then go to IDLE. No done pulse is issued.
- Undefined: ERR does not exist and align_err is tied 0.
  - Halfword ignores addr[0].
  - Word ignores addr[1:0]; it is written to the aligned word.

## Test plan
- Word store, MEM_LAT=1: addr=0x0000_0104, size=00, wdata=0xDEADBEEF.
  - Required: mem_wr=1 one cycle after accept with mem_addr=0x104 and mem_wdata=0xDEADBEEF.
  - Required: done pulse the following cycle.
- Byte store sweep: mem_rdata=0x11223344, wdata=0x000000AA, offsets 0..3.
  - Required mem_wdata: 0x112233AA, 0x1122AA44, 0x11AA3344, 0xAA223344.
- Halfword store, MEM_LAT=3: mem_rdata=0x11223344, wdata=0x0000BEEF.
  - addr=0x202 -> mem_wdata=0xBEEF3344. addr=0x200 -> mem_wdata=0x1122BEEF.
  - Required: mem_wr in cycle E0+4, done in cycle E0+5.
- Reset abort: assert reset during READ of a byte store.
  - Required: no mem_wr pulse, no done pulse, busy=0 the next cycle.
  - Required: a following word store completes normally.
- Busy/req collision: hold req=1 for the entire transaction.
  - Required: exactly one write per acceptance.
  - Required: the second acceptance occurs only in the cycle after DONE.
- With STORE_RMW_ALIGN_CHECK_EN: halfword at addr=0x301.
  - Required: align_err pulse in cycle E0+1, mem_wr never asserted, no done.
- Without STORE_RMW_ALIGN_CHECK_EN: the same stimulus writes the halfword to lanes [15:0] of 0x300.
